// File: rtl/lorenz_pkg.sv
// Shared types and constants for the Lorenz integration sequencer.
// Holds the default Q-format, FSM encoding and seed values.
package lorenz_pkg;

    localparam int INTEGER_BITS  = 6;
    localparam int FRACTION_BITS = 25;
    localparam int TOTAL_BITS    = 1 + INTEGER_BITS + FRACTION_BITS;

    typedef logic signed [TOTAL_BITS-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        EMIT  = 2'd2,
        FAULT = 2'd3
    } seq_state_t;

    localparam int START_X_WHOLE = 8;
    localparam int START_Y_WHOLE = 8;
    localparam int START_Z_WHOLE = 27;
    localparam int LIMIT_WHOLE   = 62;

    // Whole number to fixed-point code with frac_bits fractional bits.
    function automatic longint q_scale(input int whole, input int frac_bits);
        return longint'(whole) <<< frac_bits;
    endfunction

endpackage

// File: rtl/lorenz_sequencer_if.sv
// Step-engine and sample-stream channels of the Lorenz sequencer.
// master = sequencer side, slave = engine/consumer side.
interface lorenz_sequencer_if
    import lorenz_pkg::*;
#(
    parameter int totalBits = TOTAL_BITS,
    parameter int dtBits    = 16
);
    logic                        step_req;
    logic                        step_ack;
    logic signed [totalBits-1:0] cur_x;
    logic signed [totalBits-1:0] cur_y;
    logic signed [totalBits-1:0] cur_z;
    logic signed [dtBits-1:0]    step_dt;
    logic signed [totalBits-1:0] nxt_x;
    logic signed [totalBits-1:0] nxt_y;
    logic signed [totalBits-1:0] nxt_z;

    logic                        smp_valid;
    logic                        smp_ready;
    logic signed [totalBits-1:0] smp_x;
    logic signed [totalBits-1:0] smp_y;
    logic signed [totalBits-1:0] smp_z;

    modport master (
        output step_req, cur_x, cur_y, cur_z, step_dt,
        input  step_ack, nxt_x, nxt_y, nxt_z,
        output smp_valid, smp_x, smp_y, smp_z,
        input  smp_ready
    );

    modport slave (
        input  step_req, cur_x, cur_y, cur_z, step_dt,
        output step_ack, nxt_x, nxt_y, nxt_z,
        input  smp_valid, smp_x, smp_y, smp_z,
        output smp_ready
    );
endinterface

// File: rtl/lorenz_sequencer.sv
// Sequences one Lorenz integration step at a time through an external engine,
// emits a handshaked sample every `steps` steps and traps divergence.
module lorenz_sequencer
    import lorenz_pkg::*;
#(
    parameter int     integerBits  = INTEGER_BITS,
    parameter int     fractionBits = FRACTION_BITS,
    parameter int     dtBits       = 16,
    parameter int     countBits    = 16,
    parameter longint startX       = q_scale(START_X_WHOLE, fractionBits),
    parameter longint startY       = q_scale(START_Y_WHOLE, fractionBits),
    parameter longint startZ       = q_scale(START_Z_WHOLE, fractionBits),
    parameter longint limitMag     = q_scale(LIMIT_WHOLE, fractionBits),
    parameter int     defaultDt    = 1024,
    parameter int     defaultSteps = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic signed [dtBits-1:0] cfg_dt,
    input  logic [countBits-1:0]     cfg_steps,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     reseed,
    output logic                     busy,
    output logic                     diverged,
    lorenz_sequencer_if.master       bus
);
    localparam int totalBits = 1 + integerBits + fractionBits;

    localparam logic signed [totalBits-1:0] SEED_X = totalBits'(startX);
    localparam logic signed [totalBits-1:0] SEED_Y = totalBits'(startY);
    localparam logic signed [totalBits-1:0] SEED_Z = totalBits'(startZ);
    localparam logic [totalBits:0]          LIMIT  = (totalBits+1)'(limitMag);

    seq_state_t                  state, state_n;
    logic signed [totalBits-1:0] x, y, z;
    logic [countBits-1:0]        count, count_inc, steps, steps_eff;
    logic signed [dtBits-1:0]    dt;
    logic                        stop_pending, pending_n;
    logic                        load_seed, take_step, clear_count, range_bad;

    // Magnitude on one extra bit so the most negative code lands above any limit.
    function automatic logic out_of_range(input logic signed [totalBits-1:0] v);
        logic signed [totalBits:0] ext;
        logic [totalBits:0]        mag;
        ext = {v[totalBits-1], v};
        mag = ext[totalBits] ? $unsigned(-ext) : $unsigned(ext);
        return mag >= LIMIT;
    endfunction

    assign count_inc = count + countBits'(1);
    assign steps_eff = (steps == '0) ? countBits'(1) : steps;
    assign range_bad = out_of_range(bus.nxt_x) || out_of_range(bus.nxt_y) ||
                       out_of_range(bus.nxt_z);

    always_comb begin
        state_n     = state;
        load_seed   = 1'b0;
        take_step   = 1'b0;
        clear_count = 1'b0;
        case (state)
            IDLE, FAULT: begin
                load_seed = reseed;
                if (start) begin
                    state_n     = STEP;
                    clear_count = 1'b1;
                end
            end
            STEP: begin
                if (bus.step_ack) begin
                    take_step = 1'b1;
                    if (range_bad)
                        state_n = FAULT;
                    else if (count_inc == steps_eff)
                        state_n = EMIT;
                end
            end
            EMIT: begin
                if (bus.smp_ready) begin
                    clear_count = 1'b1;
                    state_n     = (stop_pending || stop) ? IDLE : STEP;
                end
            end
            default: state_n = IDLE;
        endcase

        pending_n = stop_pending;
        if (state == IDLE && start)
            pending_n = stop;
        else if (state == FAULT && start)
            pending_n = 1'b0;
        else if ((state == STEP || state == EMIT) && stop)
            pending_n = 1'b1;
        if (state_n == IDLE)
            pending_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            x             <= SEED_X;
            y             <= SEED_Y;
            z             <= SEED_Z;
            count         <= '0;
            dt            <= dtBits'(defaultDt);
            steps         <= countBits'(defaultSteps);
            stop_pending  <= 1'b0;
            bus.step_req  <= 1'b0;
            bus.smp_valid <= 1'b0;
            busy          <= 1'b0;
            diverged      <= 1'b0;
        end else begin
            state         <= state_n;
            stop_pending  <= pending_n;
            bus.step_req  <= (state_n == STEP);
            bus.smp_valid <= (state_n == EMIT);
            busy          <= (state_n == STEP) || (state_n == EMIT);
            diverged      <= (state_n == FAULT);
            if (state == IDLE && cfg_load) begin
                dt    <= cfg_dt;
                steps <= cfg_steps;
            end
            if (load_seed) begin
                x <= SEED_X;
                y <= SEED_Y;
                z <= SEED_Z;
            end else if (take_step) begin
                x <= bus.nxt_x;
                y <= bus.nxt_y;
                z <= bus.nxt_z;
            end
            if (clear_count)
                count <= '0;
            else if (take_step)
                count <= count_inc;
        end
    end

    assign bus.cur_x   = x;
    assign bus.cur_y   = y;
    assign bus.cur_z   = z;
    assign bus.smp_x   = x;
    assign bus.smp_y   = y;
    assign bus.smp_z   = z;
    assign bus.step_dt = dt;

endmodule

// File: tb/tb_lorenz_sequencer.sv
// Bench for lorenz_sequencer with a +1 LSB stub engine, randomized engine
// stalls/step counts and a step-counting reference model of the sample values.
module tb_lorenz_sequencer;

    localparam logic signed [31:0] SX      = 32'sh1000_0000;  // 8.0
    localparam logic signed [31:0] SZ      = 32'sh3600_0000;  // 27.0
    localparam logic signed [31:0] Z63     = 32'sh7E00_0000;  // 63.0
    localparam logic signed [31:0] LIM     = 32'sh7C00_0000;  // 62.0
    localparam logic signed [31:0] NEG_MAX = 32'sh8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_load = 1'b0, start = 1'b0, stop = 1'b0, reseed = 1'b0;
    logic ready = 1'b0, ack_en = 1'b1, ack_rand = 1'b0;
    logic ovr_x = 1'b0, ovr_z = 1'b0;
    logic signed [31:0] ovr_x_val = '0, ovr_z_val = '0;
    logic signed [15:0] cfg_dt = 16'sd1024;
    logic [15:0]        cfg_steps = 16'd4;
    logic busy, diverged;
    logic signed [31:0] xe;
    int acks = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lorenz_sequencer_if #(.totalBits(32), .dtBits(16)) bus ();

    lorenz_sequencer dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_dt(cfg_dt),
        .cfg_steps(cfg_steps), .start(start), .stop(stop), .reseed(reseed),
        .busy(busy), .diverged(diverged), .bus(bus)
    );

    // Stub engine: answers in the request cycle with cur + 1 LSB, optionally overridden.
    assign bus.step_ack  = bus.step_req & ack_en;
    assign bus.nxt_x     = ovr_x ? ovr_x_val : bus.cur_x + 32'sd1;
    assign bus.nxt_y     = bus.cur_y + 32'sd1;
    assign bus.nxt_z     = ovr_z ? ovr_z_val : bus.cur_z + 32'sd1;
    assign bus.smp_ready = ready;

    always @(posedge clk)
        if (bus.step_req && bus.step_ack) acks <= acks + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ack_rand) ack_en = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(input int bound, output int cycles);
        cycles = 0;
        while (!bus.smp_valid && cycles < bound) begin
            tick();
            cycles++;
        end
        if (!bus.smp_valid) check_val("smp_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic handshake(input logic with_stop);
        ready = 1'b1;
        stop  = with_stop;
        tick();
        ready = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cyc, n, nsmp;

        // Reset state
        repeat (2) tick();
        check_val("rst_step_req", bus.step_req, 0);
        check_val("rst_smp_valid", bus.smp_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_diverged", diverged, 0);
        check_val("rst_cur_x", bus.cur_x, SX);
        check_val("rst_cur_y", bus.cur_y, SX);
        check_val("rst_cur_z", bus.cur_z, SZ);
        check_val("rst_step_dt", bus.step_dt, 16'sd1024);
        rst = 1'b0;
        xe = SX;

        // Four-step sample with zero-wait engine
        cfg_load = 1'b1; cfg_steps = 16'd4;
        tick();
        cfg_load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        base = acks;
        check_val("start_step_req", bus.step_req, 1);
        check_val("start_busy", busy, 1);
        wait_valid(50, cyc);
        xe = xe + 32'sd4;
        check_val("s1_latency", cyc, 4);
        check_val("s1_acks", acks - base, 4);
        check_val("s1_smp_x", bus.smp_x, xe);
        check_val("s1_smp_z", bus.smp_z, SZ + 32'sd4);
        check_val("s1_busy", busy, 1);
        check_val("s1_step_req", bus.step_req, 0);

        // Consumer back-pressure
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("stall_smp_x", bus.smp_x, xe);
            check_val("stall_valid", bus.smp_valid, 1);
            check_val("stall_step_req", bus.step_req, 0);
        end
        check_val("stall_acks", acks - base, 4);
        handshake(1'b0);
        check_val("hs_valid_low", bus.smp_valid, 0);
        check_val("hs_step_req", bus.step_req, 1);
        base = acks;
        wait_valid(50, cyc);
        xe = xe + 32'sd4;
        check_val("s2_latency", cyc, 4);
        check_val("s2_acks", acks - base, 4);
        check_val("s2_smp_x", bus.smp_x, xe);

        // stop together with handshake goes idle
        handshake(1'b1);
        check_val("stop_hs_busy", busy, 0);
        check_val("stop_hs_step_req", bus.step_req, 0);

        // stop mid-STEP with steps=8 finishes the current sample
        cfg_load = 1'b1; cfg_steps = 16'd8;
        tick();
        cfg_load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        base = acks;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_valid(50, cyc);
        xe = xe + 32'sd8;
        check_val("stop_acks", acks - base, 8);
        check_val("stop_smp_x", bus.smp_x, xe);
        handshake(1'b0);
        base = acks;
        repeat (5) tick();
        check_val("stop_idle_busy", busy, 0);
        check_val("stop_idle_step_req", bus.step_req, 0);
        check_val("stop_idle_acks", acks - base, 0);

        // cfg_load outside IDLE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        base = acks;
        tick();
        cfg_load = 1'b1; cfg_dt = -16'sd512; cfg_steps = 16'd2;
        tick();
        cfg_load = 1'b0;
        check_val("busy_load_dt", bus.step_dt, 16'sd1024);
        wait_valid(50, cyc);
        xe = xe + 32'sd8;
        check_val("busy_load_acks", acks - base, 8);
        check_val("busy_load_smp_x", bus.smp_x, xe);
        handshake(1'b1);

        // Load in IDLE; steps=0 behaves as one step per sample
        cfg_load = 1'b1; cfg_dt = -16'sd512; cfg_steps = 16'd0;
        tick();
        cfg_load = 1'b0;
        check_val("idle_load_dt", bus.step_dt, -16'sd512);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            base = acks;
            wait_valid(20, cyc);
            xe = xe + 32'sd1;
            check_val("zero_steps_acks", acks - base, 1);
            check_val("zero_steps_smp_x", bus.smp_x, xe);
            handshake(1'b0);
        end
        base = acks;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_valid(20, cyc);
        xe = xe + 32'sd1;
        check_val("zero_steps_last_x", bus.smp_x, xe);
        handshake(1'b0);
        check_val("zero_steps_idle", busy, 0);

        // Randomized step counts, engine stalls and consumer delays
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 5);
            nsmp = $urandom_range(2, 3);
            cfg_load = 1'b1; cfg_steps = 16'(n);
            tick();
            cfg_load = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            ack_rand = 1'b1;
            for (int s = 0; s < nsmp; s++) begin
                base = acks;
                wait_valid(300, cyc);
                xe = xe + 32'(n);
                check_val("rand_acks", acks - base, n);
                check_val("rand_smp_x", bus.smp_x, xe);
                check_val("rand_smp_y", bus.smp_y, xe);
                repeat ($urandom_range(0, 3)) tick();
                handshake(s == nsmp - 1);
            end
            ack_rand = 1'b0;
            ack_en = 1'b1;
            check_val("rand_end_busy", busy, 0);
        end

        // Divergence on z at step 2, then reseed+start recovers
        reseed = 1'b1; cfg_load = 1'b1; cfg_steps = 16'd4;
        tick();
        reseed = 1'b0; cfg_load = 1'b0;
        check_val("reseed_x", bus.cur_x, SX);
        check_val("reseed_z", bus.cur_z, SZ);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ovr_z = 1'b1; ovr_z_val = Z63;
        tick();
        ovr_z = 1'b0;
        check_val("div_flag", diverged, 1);
        check_val("div_step_req", bus.step_req, 0);
        check_val("div_smp_valid", bus.smp_valid, 0);
        check_val("div_busy", busy, 0);
        check_val("div_cur_z", bus.cur_z, Z63);
        check_val("div_cur_x", bus.cur_x, SX + 32'sd2);
        base = acks;
        repeat (3) tick();
        check_val("div_hold_valid", bus.smp_valid, 0);
        check_val("div_hold_flag", diverged, 1);
        check_val("div_hold_acks", acks - base, 0);
        reseed = 1'b1; start = 1'b1;
        tick();
        reseed = 1'b0; start = 1'b0;
        check_val("recover_flag", diverged, 0);
        check_val("recover_z", bus.cur_z, SZ);
        check_val("recover_x", bus.cur_x, SX);
        check_val("recover_step_req", bus.step_req, 1);
        wait_valid(50, cyc);
        check_val("recover_smp_x", bus.smp_x, SX + 32'sd4);
        handshake(1'b1);

        // |z| exactly at the limit faults; start alone does not reseed
        start = 1'b1;
        tick();
        start = 1'b0;
        ovr_z = 1'b1; ovr_z_val = LIM;
        tick();
        ovr_z = 1'b0;
        check_val("limit_eq_flag", diverged, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_no_reseed_z", bus.cur_z, LIM);
        check_val("start_no_reseed_flag", diverged, 0);
        tick();
        check_val("limit_plus_flag", diverged, 1);

        // One LSB below the limit stays in range
        reseed = 1'b1; start = 1'b1;
        ovr_z = 1'b1; ovr_z_val = LIM - 32'sd1;
        tick();
        reseed = 1'b0; start = 1'b0;
        wait_valid(50, cyc);
        check_val("limit_below_flag", diverged, 0);
        check_val("limit_below_smp_z", bus.smp_z, LIM - 32'sd1);
        check_val("limit_below_smp_x", bus.smp_x, SX + 32'sd4);
        ovr_z = 1'b0;

        // Most negative code is out of range
        ovr_x = 1'b1; ovr_x_val = NEG_MAX;
        handshake(1'b0);
        tick();
        ovr_x = 1'b0;
        check_val("neg_max_flag", diverged, 1);
        check_val("neg_max_cur_x", bus.cur_x, NEG_MAX);

        // Reset while a sample is pending
        reseed = 1'b1; start = 1'b1;
        tick();
        reseed = 1'b0; start = 1'b0;
        wait_valid(50, cyc);
        check_val("pre_rst_valid", bus.smp_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("emit_rst_valid", bus.smp_valid, 0);
        check_val("emit_rst_step_req", bus.step_req, 0);
        check_val("emit_rst_busy", busy, 0);
        check_val("emit_rst_diverged", diverged, 0);
        check_val("emit_rst_x", bus.cur_x, SX);
        check_val("emit_rst_y", bus.cur_y, SX);
        check_val("emit_rst_z", bus.cur_z, SZ);
        check_val("emit_rst_dt", bus.step_dt, 16'sd1024);

        // Default step count after reset
        start = 1'b1;
        tick();
        start = 1'b0;
        base = acks;
        wait_valid(300, cyc);
        check_val("default_steps_acks", acks - base, 64);
        check_val("default_steps_smp_x", bus.smp_x, SX + 32'sd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lorenz_sequencer.md
# lorenz_sequencer

Controller that sequences the fixed-point Lorenz step datapath. It owns the x/y/z state registers and requests one integration step at a time from a shared step engine. After a programmed number of steps it publishes a sample to a downstream consumer over a valid/ready handshake, and it traps numeric divergence. It sits between configuration logic and the output DAC/streaming path, replacing free-running integration with handshaked, back-pressurable sampling.

## Interface
Parameters:
- `integerBits`, 6, integer bits of the state format
- `fractionBits`, 25, fraction bits; state is signed Q(integerBits).(fractionBits), `totalBits` = 1+integerBits+fractionBits
- `dtBits`, 16, width of the signed step size
- `countBits`, 16, width of the steps-per-sample counter
- `startX` / `startY` / `startZ`, 8.0 / 8.0 / 27.0 (scaled by 2^fractionBits), seed state
- `limitMag`, 62.0 (scaled), divergence threshold on |x|, |y|, |z|
- `defaultDt`, 1024, reset value of the dt register
- `defaultSteps`, 64, reset value of the steps register

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_load`  in  1  latch `cfg_dt`/`cfg_steps`; honoured only in IDLE
- `cfg_dt`  in  dtBits  signed step size
- `cfg_steps`  in  countBits  steps per sample; 0 is treated as 1
- `start`  in  1  begin/resume integration
- `stop`  in  1  request halt at next sample boundary
- `reseed`  in  1  reload start values; honoured only in IDLE or FAULT
- `step_req`  out  1  step request to engine
- `step_ack`  in  1  engine result valid this cycle
- `cur_x/cur_y/cur_z`  out  totalBits  current state to engine
- `step_dt`  out  dtBits  latched dt to engine
- `nxt_x/nxt_y/nxt_z`  in  totalBits  engine result, valid with `step_ack`
- `smp_valid`  out  1  sample available
- `smp_ready`  in  1  consumer accepts
- `smp_x/smp_y/smp_z`  out  totalBits  sample data
- `busy`  out  1  FSM not in IDLE or FAULT
- `diverged`  out  1  FAULT state flag

## Operation
- States are IDLE, STEP, EMIT and FAULT.
- IDLE:
  - `cfg_load` latches dt and steps.
  - `reseed` loads start values.
  - `start` clears `stop_pending` and the counter, then moves to STEP.
  - `stop` has no effect.
- STEP:
  - `step_req`=1 throughout.
  - Each cycle with `step_ack`: state ← nxt, count ← count+1.
  - Range check runs on nxt. If any |nxt| ≥ limitMag, go to FAULT; the state is still updated.
  - Otherwise, when count+1 == steps (0→1), go to EMIT.
  - A step in flight is never aborted.
- EMIT:
  - `smp_valid`=1. `smp_*` equal the state registers, stable until handshake.
  - On `smp_valid && smp_ready`, count ← 0, then:
    - go to IDLE if `stop_pending` or `stop` is high this cycle;
    - otherwise go to STEP.
- FAULT:
  - `diverged`=1, `step_req`=0, `smp_valid`=0.
  - `reseed` reloads start values.
  - `start` clears the flag, zeroes the counter and goes to STEP. It does not reseed unless `reseed` is also high.
- `stop` in STEP or EMIT sets `stop_pending`. The flag is cleared on entering IDLE.
- Simultaneous events:
  - `start` + `stop` in IDLE: start wins, and `stop_pending` is set.
  - `reseed` + `start`: reseed applies first, then the block starts.
  - `cfg_load` outside IDLE is ignored.
- Arithmetic:
  - Counter compare uses unsigned countBits.
  - Range check is a magnitude compare on sign-extended values. The most negative code counts as out of range.
- `rst` has priority over all inputs. Reset values:
  - FSM IDLE;
  - state = start values;
  - count 0;
  - dt = defaultDt, steps = defaultSteps;
  - `step_req`, `smp_valid`, `busy`, `diverged`, `stop_pending` = 0.

## Timing
- All outputs are registered, except `cur_*`, `smp_*` and `step_dt`, which are direct register outputs. No combinational path runs from inputs to outputs.
- `start` sampled at edge E0 → `step_req` high from E0.
- If the engine acks every cycle, N steps complete at E1..EN and `smp_valid` rises after EN.
- `cur_*` reflects the updated state the cycle after each ack. The engine may ack back-to-back.
- Sample handshake at edge Es → `step_req` high after Es (1-cycle turnaround); `smp_valid` low after Es.
- Throughput is N+1 cycles per sample with zero-wait engine and consumer.
- Divergence detected on the ack edge → `diverged` high the next cycle; no sample is emitted.

## Structure
- Package `lorenz_pkg`:
  - `totalBits` derivation and state type;
  - FSM enum (IDLE/STEP/EMIT/FAULT);
  - default start constants;
  - Q-format scale helper.
- Natural sub-module: `lorenz_step`, the multi-cycle engine. It is instantiated beside the sequencer, not inside it. The sequencer is a single module.

## Test plan
- Reset, then `start` with steps=4 and a 1-cycle-ack stub engine (nxt = cur + 1 LSB): `smp_valid` after the 4th ack, smp_x = startX+4, `busy`=1.
- `smp_ready` held low 10 cycles: `smp_*` stable, `step_req`=0, no count change; releasing it restarts stepping the next cycle.
- Stub returns nxt_z = 63.0 on step 2: `diverged`=1 the cycle after, no sample; `reseed`+`start` restores z = 27.0 and `diverged`=0.
- `stop` mid-STEP with steps=8: the current sample completes and is emitted, then IDLE with `busy`=0 and no further `step_req`.
- `cfg_load` with dt=−512 in STEP is ignored (`step_dt` stays 1024); the same load in IDLE gives `step_dt`=−512; cfg_steps=0 emits every step.
- `rst` asserted in EMIT with `smp_valid`=1: the next cycle shows all outputs at reset values and state = (8, 8, 27).
